// File: rtl/shift_seq_ctrl_pkg.sv
// Shared types and defaults for the shift sequencer.
package shift_seq_pkg;

  localparam int W_DEFAULT = 6;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

endpackage

// File: rtl/shift_seq_ctrl_if.sv
// Requester/chain-side bundle for shift_seq_ctrl.
// Handshake: a requester raises reqN with dataN and holds both stable until it
// sees the one-cycle gntN pulse; in the cycle after gntN it either drops reqN or
// presents its next word (a req still high when the sequencer is back in IDLE is
// a new word). done pulses for one cycle once par_out holds the serialised word.
interface shift_seq_ctrl_if #(
  parameter int W = shift_seq_pkg::W_DEFAULT
) ();
  import shift_seq_pkg::*;

  logic         req0;
  logic [W-1:0] data0;
  logic         req1;
  logic [W-1:0] data1;
  logic         gnt0;
  logic         gnt1;
  logic         sh_en;
  logic         sd;
  logic         busy;
  logic         done;
  logic         owner;
  logic [W-1:0] par_out;
  state_t       dbg_state;

  // Requester / observer side.
  modport master (
    output req0, data0, req1, data1,
    input  gnt0, gnt1, sh_en, sd, busy, done, owner, par_out, dbg_state
  );

  // Sequencer side.
  modport slave (
    input  req0, data0, req1, data1,
    output gnt0, gnt1, sh_en, sd, busy, done, owner, par_out, dbg_state
  );

endinterface

// File: rtl/shift_seq_ctrl_shift_chain.sv
// W-stage serial-in DFF chain: stage 0 takes the serial bit, data moves upward.
module shift_chain #(
  parameter int W = shift_seq_pkg::W_DEFAULT
) (
  input  logic         clk,
  input  logic         clear,
  input  logic         en,
  input  logic         d,
  output logic [W-1:0] q
);

  // Shift one place toward bit W-1 on each enabled edge; clear wins.
  always_ff @(posedge clk) begin
    if (!clear) begin
      q <= '0;
    end else if (en) begin
      q <= {q[W-2:0], d};
    end
  end

endmodule

// File: rtl/shift_seq_ctrl.sv
// Round-robin sequencer that serialises a granted word MSB-first into a chain.
module shift_seq_ctrl
  import shift_seq_pkg::*;
#(
  parameter int W = W_DEFAULT
) (
  input  logic                 clk,
  input  logic                 clear,
  shift_seq_ctrl_if.slave      bus
);

  localparam int CW = (W > 2) ? $clog2(W) : 1;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [W-1:0]   hold_q, hold_d;
  logic           owner_q, owner_d;
  logic           rr_q, rr_d;      // 0: prefer req0 on a tie, 1: prefer req1
  logic           gnt0_q, gnt0_d;
  logic           gnt1_q, gnt1_d;
  logic           sh_en_q, sh_en_d;
  logic           sd_q, sd_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;

  logic           sel;
  logic [W-1:0]   sel_data;
  logic [CW-1:0]  nxt_idx;
  logic [W-1:0]   chain_q;

  // Single requester wins outright; on a tie the pointer decides.
  assign sel      = (bus.req0 && bus.req1) ? rr_q : bus.req1;
  assign sel_data = sel ? bus.data1 : bus.data0;
  // Bit to present on the next shift cycle; only used while cnt_q < W-1.
  assign nxt_idx  = CW'(W - 2) - cnt_q;

  // Next-state and next-output decode; every output is registered below.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hold_d  = hold_q;
    owner_d = owner_q;
    rr_d    = rr_q;
    gnt0_d  = 1'b0;
    gnt1_d  = 1'b0;
    sh_en_d = 1'b0;
    sd_d    = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.req0 || bus.req1) begin
          hold_d  = sel_data;
          owner_d = sel;
          rr_d    = ~sel;
          gnt0_d  = ~sel;
          gnt1_d  = sel;
          cnt_d   = '0;
          sh_en_d = 1'b1;
          sd_d    = sel_data[W-1];
          busy_d  = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        busy_d = 1'b1;
        if (cnt_q == CW'(W - 1)) begin
          cnt_d   = '0;
          done_d  = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d   = cnt_q + CW'(1);
          sh_en_d = 1'b1;
          sd_d    = hold_q[nxt_idx];
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, datapath and output registers with synchronous clear.
  always_ff @(posedge clk) begin
    if (!clear) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hold_q  <= '0;
      owner_q <= 1'b0;
      rr_q    <= 1'b0;
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      sh_en_q <= 1'b0;
      sd_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
      owner_q <= owner_d;
      rr_q    <= rr_d;
      gnt0_q  <= gnt0_d;
      gnt1_q  <= gnt1_d;
      sh_en_q <= sh_en_d;
      sd_q    <= sd_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  shift_chain #(.W(W)) u_chain (
    .clk   (clk),
    .clear (clear),
    .en    (sh_en_q),
    .d     (sd_q),
    .q     (chain_q)
  );

  assign bus.gnt0      = gnt0_q;
  assign bus.gnt1      = gnt1_q;
  assign bus.sh_en     = sh_en_q;
  assign bus.sd        = sd_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.owner     = owner_q;
  assign bus.par_out   = chain_q;
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Directed and randomized bench for shift_seq_ctrl with a transaction-level model.
module tb_shift_seq_ctrl;
  import shift_seq_pkg::*;

  localparam int W = 6;

  logic clk = 1'b0;
  logic clear = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   model_ptr = 0;          // requester favoured on the next tie
  logic [W-1:0] exp_q[$];

  shift_seq_ctrl_if #(.W(W)) bus ();

  shift_seq_ctrl #(.W(W)) dut (
    .clk   (clk),
    .clear (clear),
    .bus   (bus.slave)
  );

  // Clock and cycle counter.
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Hard time limit.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Round-robin rule: a lone request wins, a tie goes to the favoured one.
  function automatic int pick(input logic r0, input logic r1);
    if (r0 && r1) return model_ptr;
    return r1 ? 1 : 0;
  endfunction

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_gnt0"},    bus.gnt0, 0);
    chk({tag, "_gnt1"},    bus.gnt1, 0);
    chk({tag, "_sh_en"},   bus.sh_en, 0);
    chk({tag, "_sd"},      bus.sd, 0);
    chk({tag, "_busy"},    bus.busy, 0);
    chk({tag, "_done"},    bus.done, 0);
    chk({tag, "_owner"},   bus.owner, 0);
    chk({tag, "_par_out"}, bus.par_out, 0);
    chk({tag, "_state"},   bus.dbg_state, IDLE);
  endtask

  task automatic pulse_clear();
    clear = 1'b0;
    @(negedge clk);
    clear = 1'b1;
    model_ptr = 0;
    exp_q.delete();
  endtask

  // One complete word: wait for grant, follow W shift cycles, DONE, IDLE.
  // keep: winner presents a fresh word instead of dropping its request.
  // hook: 1 raises req1 in DONE and drops it in IDLE, 2 raises and holds it.
  task automatic xfer(input bit keep, input int hook,
                      output int who, output int waited, output int done_cyc);
    int exp_who;
    logic [W-1:0] word;
    bit got;
    exp_who = pick(bus.req0, bus.req1);
    word = (exp_who == 1) ? bus.data1 : bus.data0;
    exp_q.push_back(word);
    got = 1'b0;
    waited = 0;
    who = -1;
    done_cyc = 0;
    for (int i = 0; i < 4 * W && !got; i++) begin
      @(negedge clk);
      waited++;
      if (bus.gnt0 || bus.gnt1) got = 1'b1;
    end
    chk("grant_seen", got, 1);
    if (!got) begin
      void'(exp_q.pop_back());
      return;
    end
    who = bus.gnt1 ? 1 : 0;
    chk("grant_who", who, exp_who);
    chk("gnt_onehot", bus.gnt0 & bus.gnt1, 0);
    model_ptr = 1 - exp_who;
    if (exp_who == 0) begin
      if (keep) bus.data0 = W'($urandom); else bus.req0 = 1'b0;
    end else begin
      if (keep) bus.data1 = W'($urandom); else bus.req1 = 1'b0;
    end
    for (int k = 0; k < W; k++) begin
      if (k > 0) begin
        @(negedge clk);
        chk("shift_gnt", bus.gnt0 | bus.gnt1, 0);
      end
      chk("shift_sh_en", bus.sh_en, 1);
      chk("shift_sd", bus.sd, word[W-1-k]);
      chk("shift_busy", bus.busy, 1);
      chk("shift_done", bus.done, 0);
    end
    @(negedge clk);
    done_cyc = cyc;
    chk("done_pulse", bus.done, 1);
    chk("done_sh_en", bus.sh_en, 0);
    chk("done_busy", bus.busy, 1);
    chk("done_gnt", bus.gnt0 | bus.gnt1, 0);
    chk("done_owner", bus.owner, exp_who);
    chk("done_par_out", bus.par_out, exp_q.pop_front());
    if (hook != 0) bus.req1 = 1'b1;
    @(negedge clk);
    chk("idle_done", bus.done, 0);
    chk("idle_busy", bus.busy, 0);
    chk("idle_sh_en", bus.sh_en, 0);
    chk("idle_gnt", bus.gnt0 | bus.gnt1, 0);
    chk("idle_par_hold", bus.par_out, word);
    if (hook == 1) bus.req1 = 1'b0;
  endtask

  initial begin
    int who, waited, dc0, dc1, t;
    bit r0, r1;

    // 1: reset with random request activity.
    clear = 1'b0;
    bus.req0 = 1'($urandom);
    bus.req1 = 1'($urandom);
    bus.data0 = W'($urandom);
    bus.data1 = W'($urandom);
    @(negedge clk);
    @(negedge clk);
    chk_reset_outputs("reset");
    bus.req0 = 1'b1;
    bus.req1 = 1'b1;
    clear = 1'b1;
    xfer(1'b0, 0, who, waited, t);
    chk("t1_first_grant_req0", who, 0);
    bus.req1 = 1'b0;

    // 2: single word from requester 0.
    bus.req0 = 1'b1;
    bus.data0 = 6'b101101;
    xfer(1'b0, 0, who, waited, t);
    chk("t2_who", who, 0);
    chk("t2_latency", waited, 1);

    // 3: simultaneous requests after reset.
    pulse_clear();
    bus.req0 = 1'b1;
    bus.req1 = 1'b1;
    bus.data0 = 6'b000111;
    bus.data1 = 6'b111000;
    xfer(1'b0, 0, who, waited, dc0);
    chk("t3_first", who, 0);
    xfer(1'b0, 0, who, waited, dc1);
    chk("t3_second", who, 1);
    chk("t3_done_spacing", dc1 - dc0, W + 2);

    // 4: both held with fresh data, then req1 alone.
    bus.req0 = 1'b1;
    bus.req1 = 1'b1;
    bus.data0 = W'($urandom);
    bus.data1 = W'($urandom);
    xfer(1'b1, 0, who, waited, t);
    chk("t4_g0", who, 0);
    xfer(1'b1, 0, who, waited, t);
    chk("t4_g1", who, 1);
    xfer(1'b0, 0, who, waited, t);
    chk("t4_g2", who, 0);
    xfer(1'b1, 0, who, waited, t);
    chk("t4_g3", who, 1);
    xfer(1'b0, 0, who, waited, t);
    chk("t4_req1_again", who, 1);

    // Random traffic against the model.
    for (int n = 0; n < 10; n++) begin
      r0 = 1'($urandom_range(0, 1));
      r1 = 1'($urandom_range(0, 1));
      if (r0 && !bus.req0) begin
        bus.req0 = 1'b1;
        bus.data0 = W'($urandom);
      end
      if (r1 && !bus.req1) begin
        bus.req1 = 1'b1;
        bus.data1 = W'($urandom);
      end
      if (!bus.req0 && !bus.req1) begin
        bus.req0 = 1'b1;
        bus.data0 = W'($urandom);
      end
      xfer(1'($urandom_range(0, 1)), 0, who, waited, t);
    end
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    @(negedge clk);

    // 5: abort mid-shift.
    bus.req0 = 1'b1;
    bus.data0 = 6'b110011;
    t = 0;
    for (int i = 0; i < 4 * W && !bus.gnt0; i++) begin
      @(negedge clk);
      t++;
    end
    chk("t5_gnt0", bus.gnt0, 1);
    bus.req0 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("t5_sh_en_third", bus.sh_en, 1);
    clear = 1'b0;
    @(negedge clk);
    chk_reset_outputs("t5_abort");
    model_ptr = 0;
    exp_q.delete();
    bus.req0 = 1'b1;
    bus.req1 = 1'b1;
    bus.data0 = W'($urandom);
    bus.data1 = W'($urandom);
    clear = 1'b1;
    xfer(1'b0, 0, who, waited, t);
    chk("t5_after_release", who, 0);
    chk("t5_latency", waited, 1);
    bus.req1 = 1'b0;

    // 6: req1 only during DONE, then held into IDLE.
    bus.req0 = 1'b1;
    bus.data0 = W'($urandom);
    bus.data1 = W'($urandom);
    xfer(1'b0, 1, who, waited, t);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t6_no_gnt1", bus.gnt1, 0);
      chk("t6_no_busy", bus.busy, 0);
    end
    bus.req0 = 1'b1;
    bus.data0 = W'($urandom);
    bus.data1 = W'($urandom);
    xfer(1'b0, 2, who, waited, t);
    chk("t6_req1_pending", bus.req1, 1);
    xfer(1'b0, 0, who, waited, t);
    chk("t6_gnt1_who", who, 1);
    chk("t6_gnt1_latency", waited, 1);

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
